// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 encodings, ALU codes, stat codes and condition evaluation
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;
    localparam logic [3:0] ALU_SHL = 4'h4;
    localparam logic [3:0] ALU_SHR = 4'h5;
    localparam logic [3:0] ALU_SAR = 4'h6;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

    function automatic logic cond_eval(input logic [3:0] ifun, input cc_t cc);
        logic lt;
        lt = cc.sf ^ cc.of;
        case (ifun)
            C_YES:   return 1'b1;
            C_LE:    return lt | cc.zf;
            C_L:     return lt;
            C_E:     return cc.zf;
            C_NE:    return ~cc.zf;
            C_GE:    return ~lt;
            C_G:     return ~lt & ~cc.zf;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_core_w.sv
// rtl/alu_core_w.sv - combinational W-bit ALU with ZF/SF/OF; shifts under EXEC_EXT_OPS_EN
module alu_core_w
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   fn,
    output logic [W-1:0] result,
    output logic         zf,
    output logic         sf,
    output logic         of
);

`ifdef EXEC_EXT_OPS_EN
    localparam int SW = $clog2(W);
`endif

    always_comb begin
        result = '0;
        of     = 1'b0;
        case (fn)
            ALU_ADD: begin
                result = a + b;
                of     = (a[W-1] == b[W-1]) && (result[W-1] != a[W-1]);
            end
            ALU_SUB: begin
                // Y86 subtracts the first operand from the second
                result = b - a;
                of     = (b[W-1] != a[W-1]) && (result[W-1] != b[W-1]);
            end
            ALU_AND: result = a & b;
            ALU_XOR: result = a ^ b;
`ifdef EXEC_EXT_OPS_EN
            ALU_SHL: result = b << a[SW-1:0];
            ALU_SHR: result = b >> a[SW-1:0];
            ALU_SAR: result = W'($signed(b) >>> a[SW-1:0]);
`endif
            default: result = '0;
        endcase
        zf = (result == '0);
        sf = result[W-1];
    end

endmodule

// File: rtl/execute_pipe_stage.sv
// rtl/execute_pipe_stage.sv - pipelined execute stage: operand select, CC, Cnd, E/M register
// EXEC_EXT_OPS_EN enables the OPq shift functions and full ifun decoding.
module execute_pipe_stage
    import y86_pkg::*;
#(
    parameter int W          = 64,
    parameter int STACK_STEP = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         bubble,
    input  logic         cc_block,
    input  logic [2:0]   E_stat,
    input  logic [3:0]   E_icode,
    input  logic [3:0]   E_ifun,
    input  logic [W-1:0] E_valA,
    input  logic [W-1:0] E_valB,
    input  logic [W-1:0] E_valC,
    input  logic [3:0]   E_dstE,
    input  logic [3:0]   E_dstM,
    output logic [W-1:0] e_valE,
    output logic [3:0]   e_dstE,
    output logic         e_Cnd,
    output logic [2:0]   M_stat,
    output logic [3:0]   M_icode,
    output logic         M_Cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM,
    output logic         cc_zf,
    output logic         cc_sf,
    output logic         cc_of
);

    logic [W-1:0] alu_a, alu_b, step_pos, step_neg;
    logic [3:0]   alu_fn;
    logic         alu_zf, alu_sf, alu_of, fn_valid, set_cc;
    cc_t          cc_q, cc_d;

    logic [2:0]   m_stat_q, m_stat_d;
    logic [3:0]   m_icode_q, m_icode_d, m_dste_q, m_dste_d, m_dstm_q, m_dstm_d;
    logic         m_cnd_q, m_cnd_d;
    logic [W-1:0] m_vale_q, m_vale_d, m_vala_q, m_vala_d;

    assign step_pos = W'(STACK_STEP);
    assign step_neg = '0 - step_pos;

    always_comb begin
        alu_a = '0;
        case (E_icode)
            I_RRMOVQ, I_OPQ:                alu_a = E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:   alu_a = E_valC;
            I_CALL, I_PUSHQ:                alu_a = step_neg;
            I_RET, I_POPQ:                  alu_a = step_pos;
            default:                        alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = E_valB;
            default:                                                   alu_b = '0;
        endcase
    end

`ifdef EXEC_EXT_OPS_EN
    assign alu_fn   = (E_icode == I_OPQ) ? E_ifun : ALU_ADD;
    assign fn_valid = (E_ifun <= ALU_SAR);
`else
    assign alu_fn   = (E_icode == I_OPQ) ? {2'b00, E_ifun[1:0]} : ALU_ADD;
    assign fn_valid = 1'b1;
`endif

    alu_core_w #(.W(W)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .fn     (alu_fn),
        .result (e_valE),
        .zf     (alu_zf),
        .sf     (alu_sf),
        .of     (alu_of)
    );

    // Cnd reads the registered flags, never the ones being produced this cycle
    assign e_Cnd  = ((E_icode == I_RRMOVQ) || (E_icode == I_JXX)) ? cond_eval(E_ifun, cc_q) : 1'b0;
    assign e_dstE = ((E_icode == I_RRMOVQ) && !e_Cnd) ? RNONE : E_dstE;

    assign set_cc = (E_icode == I_OPQ) && (E_stat == STAT_AOK) && !cc_block && !stall && fn_valid;
    assign cc_d   = set_cc ? '{zf: alu_zf, sf: alu_sf, of: alu_of} : cc_q;

    always_comb begin
        m_stat_d  = m_stat_q;
        m_icode_d = m_icode_q;
        m_cnd_d   = m_cnd_q;
        m_vale_d  = m_vale_q;
        m_vala_d  = m_vala_q;
        m_dste_d  = m_dste_q;
        m_dstm_d  = m_dstm_q;
        if (!stall) begin
            if (bubble) begin
                m_stat_d  = STAT_AOK;
                m_icode_d = I_NOP;
                m_cnd_d   = 1'b0;
                m_vale_d  = '0;
                m_vala_d  = '0;
                m_dste_d  = RNONE;
                m_dstm_d  = RNONE;
            end else begin
                m_stat_d  = E_stat;
                m_icode_d = E_icode;
                m_cnd_d   = e_Cnd;
                m_vale_d  = e_valE;
                m_vala_d  = E_valA;
                m_dste_d  = e_dstE;
                m_dstm_d  = E_dstM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cc_q      <= CC_RESET;
            m_stat_q  <= STAT_AOK;
            m_icode_q <= I_NOP;
            m_cnd_q   <= 1'b0;
            m_vale_q  <= '0;
            m_vala_q  <= '0;
            m_dste_q  <= RNONE;
            m_dstm_q  <= RNONE;
        end else begin
            cc_q      <= cc_d;
            m_stat_q  <= m_stat_d;
            m_icode_q <= m_icode_d;
            m_cnd_q   <= m_cnd_d;
            m_vale_q  <= m_vale_d;
            m_vala_q  <= m_vala_d;
            m_dste_q  <= m_dste_d;
            m_dstm_q  <= m_dstm_d;
        end
    end

    assign M_stat  = m_stat_q;
    assign M_icode = m_icode_q;
    assign M_Cnd   = m_cnd_q;
    assign M_valE  = m_vale_q;
    assign M_valA  = m_vala_q;
    assign M_dstE  = m_dste_q;
    assign M_dstM  = m_dstm_q;
    assign cc_zf   = cc_q.zf;
    assign cc_sf   = cc_q.sf;
    assign cc_of   = cc_q.of;

endmodule

// File: tb/tb_execute_pipe_stage.sv
// tb/tb_execute_pipe_stage.sv - scoreboard bench for execute_pipe_stage (W=64 and W=16 instances)
module tb_execute_pipe_stage;
    import y86_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stall, bubble, cc_block;
    logic [2:0]  E_stat;
    logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
    logic [63:0] E_valA, E_valB, E_valC;
    logic [63:0] e_valE, M_valE, M_valA;
    logic [3:0]  e_dstE, M_icode, M_dstE, M_dstM;
    logic        e_Cnd, M_Cnd, cc_zf, cc_sf, cc_of;
    logic [2:0]  M_stat;

    logic [2:0]  s_E_stat, s_M_stat;
    logic [3:0]  s_E_icode, s_E_ifun, s_E_dstE, s_E_dstM;
    logic [15:0] s_E_valA, s_E_valB, s_E_valC, s_e_valE, s_M_valE, s_M_valA;
    logic [3:0]  s_e_dstE, s_M_icode, s_M_dstE, s_M_dstM;
    logic        s_e_Cnd, s_M_Cnd, s_cc_zf, s_cc_sf, s_cc_of;

    execute_pipe_stage #(.W(64), .STACK_STEP(8)) dut (
        .clk(clk), .reset(reset), .stall(stall), .bubble(bubble), .cc_block(cc_block),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
        .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
    );

    execute_pipe_stage #(.W(16), .STACK_STEP(2)) dut16 (
        .clk(clk), .reset(reset), .stall(stall), .bubble(bubble), .cc_block(cc_block),
        .E_stat(s_E_stat), .E_icode(s_E_icode), .E_ifun(s_E_ifun),
        .E_valA(s_E_valA), .E_valB(s_E_valB), .E_valC(s_E_valC),
        .E_dstE(s_E_dstE), .E_dstM(s_E_dstM),
        .e_valE(s_e_valE), .e_dstE(s_e_dstE), .e_Cnd(s_e_Cnd),
        .M_stat(s_M_stat), .M_icode(s_M_icode), .M_Cnd(s_M_Cnd),
        .M_valE(s_M_valE), .M_valA(s_M_valA), .M_dstE(s_M_dstE), .M_dstM(s_M_dstM),
        .cc_zf(s_cc_zf), .cc_sf(s_cc_sf), .cc_of(s_cc_of)
    );

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] vale;
        logic [63:0] vala;
        logic [3:0]  dste;
        logic [3:0]  dstm;
    } m_rec_t;

    m_rec_t sb[$];
    m_rec_t last_m, nop_m;
    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_cc(input string tag, input logic zf, input logic sf, input logic of);
        chk({tag, ".cc"}, {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, zf, sf, of});
    endtask

    task automatic chk_m(input string tag, input m_rec_t r);
        chk({tag, ".M_stat"},  {61'd0, M_stat},  {61'd0, r.stat});
        chk({tag, ".M_icode"}, {60'd0, M_icode}, {60'd0, r.icode});
        chk({tag, ".M_Cnd"},   {63'd0, M_Cnd},   {63'd0, r.cnd});
        chk({tag, ".M_valE"},  M_valE, r.vale);
        chk({tag, ".M_valA"},  M_valA, r.vala);
        chk({tag, ".M_dstE"},  {60'd0, M_dstE},  {60'd0, r.dste});
        chk({tag, ".M_dstM"},  {60'd0, M_dstM},  {60'd0, r.dstm});
    endtask

    // Drive one E-stage instruction, check forwarding outputs, then the E/M result after the edge
    task automatic run(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                       input logic [3:0] de, input logic [3:0] dm, input logic [2:0] st,
                       input logic [63:0] x_vale, input logic x_cnd, input logic [3:0] x_dste);
        m_rec_t r, got;
        E_icode = ic; E_ifun = fn; E_valA = va; E_valB = vb; E_valC = vc;
        E_dstE = de; E_dstM = dm; E_stat = st;
        #1;
        chk({tag, ".e_valE"}, e_valE, x_vale);
        chk({tag, ".e_Cnd"},  {63'd0, e_Cnd}, {63'd0, x_cnd});
        chk({tag, ".e_dstE"}, {60'd0, e_dstE}, {60'd0, x_dste});
        if (stall)       r = last_m;
        else if (bubble) r = nop_m;
        else r = '{stat: st, icode: ic, cnd: x_cnd, vale: x_vale, vala: va, dste: x_dste, dstm: dm};
        sb.push_back(r);
        last_m = r;
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            compared++; mismatched++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            got = sb.pop_front();
            chk_m(tag, got);
        end
    endtask

    initial begin
        nop_m = '{stat: STAT_AOK, icode: I_NOP, cnd: 1'b0, vale: 64'd0, vala: 64'd0,
                  dste: RNONE, dstm: RNONE};
        reset = 1'b1; stall = 1'b0; bubble = 1'b0; cc_block = 1'b0;
        E_stat = STAT_AOK; E_icode = I_NOP; E_ifun = 4'd0; E_valA = '0; E_valB = '0; E_valC = '0;
        E_dstE = RNONE; E_dstM = RNONE;
        s_E_stat = STAT_AOK; s_E_icode = I_NOP; s_E_ifun = 4'd0; s_E_valA = '0; s_E_valB = '0;
        s_E_valC = '0; s_E_dstE = RNONE; s_E_dstM = RNONE;
        repeat (2) @(posedge clk);
        #1;
        chk_m("reset", nop_m);
        chk_cc("reset", 1'b1, 1'b0, 1'b0);
        last_m = nop_m;
        reset = 1'b0;

        run("sub55", I_OPQ, 4'd1, 64'd5, 64'd5, 64'd0, 4'd3, RNONE, STAT_AOK, 64'd0, 1'b0, 4'd3);
        chk_cc("sub55", 1'b1, 1'b0, 1'b0);
        run("add_ovf", I_OPQ, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0,
            4'd3, RNONE, STAT_AOK, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 4'd3);
        chk_cc("add_ovf", 1'b0, 1'b1, 1'b1);
        run("sub3m7", I_OPQ, 4'd1, 64'd7, 64'd3, 64'd0, 4'd3, RNONE, STAT_AOK,
            64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 4'd3);
        chk_cc("sub3m7", 1'b0, 1'b1, 1'b0);
        run("cmovl_t", I_RRMOVQ, C_L, 64'h55, 64'h99, 64'd0, 4'd4, RNONE, STAT_AOK, 64'h55, 1'b1, 4'd4);
        run("jl_t", I_JXX, C_L, 64'd0, 64'd0, 64'h400, RNONE, RNONE, STAT_AOK, 64'd0, 1'b1, RNONE);
        run("jg_f", I_JXX, C_G, 64'd0, 64'd0, 64'h400, RNONE, RNONE, STAT_AOK, 64'd0, 1'b0, RNONE);
        run("sub7m3", I_OPQ, 4'd1, 64'd3, 64'd7, 64'd0, 4'd3, RNONE, STAT_AOK, 64'd4, 1'b0, 4'd3);
        chk_cc("sub7m3", 1'b0, 1'b0, 1'b0);
        run("cmovl_f", I_RRMOVQ, C_L, 64'h55, 64'h99, 64'd0, 4'd4, RNONE, STAT_AOK, 64'h55, 1'b0, RNONE);
        run("jg_t", I_JXX, C_G, 64'd0, 64'd0, 64'h400, RNONE, RNONE, STAT_AOK, 64'd0, 1'b1, RNONE);
        run("j7", I_JXX, 4'd7, 64'd0, 64'd0, 64'h400, RNONE, RNONE, STAT_AOK, 64'd0, 1'b0, RNONE);

        run("sub55b", I_OPQ, 4'd1, 64'd5, 64'd5, 64'd0, 4'd3, RNONE, STAT_AOK, 64'd0, 1'b0, 4'd3);
        run("pushq", I_PUSHQ, 4'd0, 64'h77, 64'h100, 64'd0, 4'd4, RNONE, STAT_AOK, 64'hF8, 1'b0, 4'd4);
        chk_cc("pushq", 1'b1, 1'b0, 1'b0);
        run("popq", I_POPQ, 4'd0, 64'h77, 64'h100, 64'd0, 4'd4, 4'd3, STAT_AOK, 64'h108, 1'b0, 4'd4);
        chk_cc("popq", 1'b1, 1'b0, 1'b0);
        run("je_t", I_JXX, C_E, 64'd0, 64'd0, 64'h80, RNONE, RNONE, STAT_AOK, 64'd0, 1'b1, RNONE);
        run("jne_f", I_JXX, C_NE, 64'd0, 64'd0, 64'h80, RNONE, RNONE, STAT_AOK, 64'd0, 1'b0, RNONE);

        cc_block = 1'b1;
        run("ccblk", I_OPQ, 4'd1, 64'd3, 64'd7, 64'd0, 4'd3, RNONE, STAT_AOK, 64'd4, 1'b0, 4'd3);
        chk_cc("ccblk", 1'b1, 1'b0, 1'b0);
        cc_block = 1'b0;
        run("stat_ins", I_OPQ, 4'd1, 64'd3, 64'd7, 64'd0, 4'd3, RNONE, STAT_INS, 64'd4, 1'b0, 4'd3);
        chk_cc("stat_ins", 1'b1, 1'b0, 1'b0);

        run("irmov", I_IRMOVQ, 4'd0, 64'hAA, 64'hBB, 64'h1234, 4'd2, RNONE, STAT_AOK, 64'h1234, 1'b0, 4'd2);
        run("mrmov", I_MRMOVQ, 4'd0, 64'd0, 64'h1000, 64'h20, RNONE, 4'd5, STAT_AOK, 64'h1020, 1'b0, RNONE);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run("stall", I_OPQ, 4'd1, 64'd3, 64'd7, 64'd0, 4'd3, RNONE, STAT_AOK, 64'd4, 1'b0, 4'd3);
            chk_cc("stall", 1'b1, 1'b0, 1'b0);
        end
        bubble = 1'b1;
        run("stall_bub", I_IRMOVQ, 4'd0, 64'd0, 64'd0, 64'h66, 4'd2, RNONE, STAT_AOK, 64'h66, 1'b0, 4'd2);
        stall = 1'b0;
        run("bubble", I_IRMOVQ, 4'd0, 64'd0, 64'd0, 64'h55, 4'd2, RNONE, STAT_AOK, 64'h55, 1'b0, 4'd2);
        chk_cc("bubble", 1'b1, 1'b0, 1'b0);
        bubble = 1'b0;

        run("and", I_OPQ, 4'd2, 64'hF0F0, 64'hFF00, 64'd0, 4'd3, RNONE, STAT_AOK, 64'hF000, 1'b0, 4'd3);
        chk_cc("and", 1'b0, 1'b0, 1'b0);
        run("xor", I_OPQ, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0F, 64'd0, 4'd3, RNONE, STAT_AOK,
            64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 4'd3);
        chk_cc("xor", 1'b0, 1'b1, 1'b0);

        s_E_icode = I_OPQ; s_E_ifun = 4'd0; s_E_valA = 16'h8000; s_E_valB = 16'h8000; s_E_dstE = 4'd3;
        #1;
        chk("w16_add.e_valE", {48'd0, s_e_valE}, 64'd0);
        @(posedge clk); #1;
        chk("w16_add.cc", {61'd0, s_cc_zf, s_cc_sf, s_cc_of}, {61'd0, 1'b1, 1'b0, 1'b1});
        chk("w16_add.M_valE", {48'd0, s_M_valE}, 64'd0);
        chk("w16_add.M_icode", {60'd0, s_M_icode}, {60'd0, I_OPQ});
        chk("w16_add.M_dstE", {60'd0, s_M_dstE}, 64'd3);

        s_E_ifun = 4'd6; s_E_valA = 16'h0004; s_E_valB = 16'h8000;
        #1;
`ifdef EXEC_EXT_OPS_EN
        chk("w16_sar.e_valE", {48'd0, s_e_valE}, 64'hF800);
        @(posedge clk); #1;
        chk("w16_sar.cc", {61'd0, s_cc_zf, s_cc_sf, s_cc_of}, {61'd0, 1'b0, 1'b1, 1'b0});
`else
        chk("w16_alias_and.e_valE", {48'd0, s_e_valE}, 64'd0);
        @(posedge clk); #1;
        chk("w16_alias_and.cc", {61'd0, s_cc_zf, s_cc_sf, s_cc_of}, {61'd0, 1'b1, 1'b0, 1'b0});
`endif
        s_E_ifun = 4'd7; s_E_valA = 16'h8000; s_E_valB = 16'h8000;
        #1;
        chk("w16_fn7.e_valE", {48'd0, s_e_valE}, 64'd0);
        @(posedge clk); #1;
`ifdef EXEC_EXT_OPS_EN
        chk("w16_fn7.cc", {61'd0, s_cc_zf, s_cc_sf, s_cc_of}, {61'd0, 1'b0, 1'b1, 1'b0});
`else
        chk("w16_fn7.cc", {61'd0, s_cc_zf, s_cc_sf, s_cc_of}, {61'd0, 1'b1, 1'b0, 1'b0});
`endif
        chk("w16.M_misc", {s_M_valA, 8'd0, s_M_stat, s_M_Cnd, s_M_dstM, s_e_Cnd, s_e_dstE, 27'd0},
            {16'h8000, 8'd0, STAT_AOK, 1'b0, RNONE, 1'b0, 4'd3, 27'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
